aux_uart_tx: RTL

AUX_UART_TX -- requirements
Module: aux_uart_tx

---
 rtl/aux_uart_pkg.sv | 25 ++
 rtl/aux_uart_tx_fifo.sv | 58 +++++
 rtl/aux_uart_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/aux_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aux_uart_pkg
// Description : Shared definitions for the auxiliary UART (tx now, rx later):
//               line-state enum, data width and bit-period computation.
// Revision    : 1.0 - initial release
// ============================================================================
package aux_uart_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per serial bit, truncating toward zero.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aux_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aux_uart_tx_fifo
// Description : Small synchronous FIFO buffering bytes ahead of the UART
//               serializer. Pointers carry one extra wrap bit so full and
//               empty can be told apart without a separate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module aux_uart_tx_fifo
  import aux_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Same low bits with differing wrap bits means the writer lapped the reader.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; push and pop on the same edge leave occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty pointers mask them.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/aux_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : aux_uart_tx
// Description : 8N1 UART transmitter with a byte FIFO and valid/ready input.
//               Frames are sent back to back while the FIFO holds data.
// Revision    : 1.0 - initial release
// ============================================================================
module aux_uart_tx
  import aux_uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int CPB = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
  localparam int BW  = (CPB < 2) ? 1 : $clog2(CPB);
  localparam logic [BW-1:0] C_BAUD_LAST = BW'(CPB - 1);

  // A bit period under two clocks cannot be timed by this counter scheme.
  if (CPB < 2) begin : g_bad_baud
    $error("aux_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("aux_uart_tx: FIFO_DEPTH must be a power of two in 2..16");
  end

  uart_state_t           r_state;
  uart_state_t           w_state_next;
  logic [BW-1:0]         r_baud;
  logic [BW-1:0]         w_baud_next;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_next;
  logic [2:0]            w_bit_inc;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  w_bit_end;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign tx_ready  = ~w_full;
  assign w_push    = tx_valid & ~w_full;
  assign w_bit_end = (r_baud == C_BAUD_LAST);
  assign w_bit_inc = r_bit + 3'd1;
  assign tx        = r_tx;
  assign busy      = (r_state != IDLE) | ~w_empty;

  aux_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (tx_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Frame state, bit timing, shift data and the registered line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // Next-state logic; the next line level is decided here so tx is a flop.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_rd_data;
          w_baud_next  = '0;
          w_state_next = START;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next = w_bit_inc;
            w_tx_next  = r_shift[w_bit_inc];
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          // Chain straight into the next start bit to avoid an idle gap.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_rd_data;
            w_state_next = START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire
